// File: rtl/lfsr_rng_stream_if.sv
// Output stream bundle for lfsr_rng_stream: random word plus valid/ready handshake.
interface lfsr_rng_stream_if #(
   parameter int OUT_W = 8
);
   logic [OUT_W-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;

   modport master (
      output dout,
      output dout_valid,
      input  dout_ready
   );

   modport slave (
      input  dout,
      input  dout_valid,
      output dout_ready
   );
endinterface

// File: rtl/lfsr_rng_stream.sv
// Parametrised Fibonacci LFSR random-word generator with warm-up discard,
// runtime reseed, advance enable and a backpressured valid/ready output.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_WARM | shifting and discarding WARMUP bits after reset or reseed
// ST_RUN  | collecting emitted bits LSB-first into OUT_W-bit words
module lfsr_rng_stream #(
   parameter int                LFSR_W = 32,
   parameter logic [LFSR_W-1:0] TAPS   = 32'h8020_0003,
   parameter logic [LFSR_W-1:0] SEED   = 3515,
   parameter int                OUT_W  = 8,
   parameter int                WARMUP = 33
) (
   input  logic                i_clk,
   input  logic                i_res,
   input  logic                i_en,
   input  logic                i_seed_ld,
   input  logic [LFSR_W-1:0]   i_seed_in,
   output logic                o_warm,
   lfsr_rng_stream_if.master   o_stream
);

   // The all-zero state is a lock-up point, so a zero seed falls back to 1.
   localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? LFSR_W'(1) : SEED;

   localparam int              CNT_W     = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

   localparam int              WC_W      = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam int              WC_LAST_I = (WARMUP > 0) ? WARMUP - 1 : 0;
   localparam logic [WC_W-1:0] WC_LAST   = WC_W'(WC_LAST_I);

   typedef enum logic {
      ST_WARM = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t             r_state;
   logic [LFSR_W-1:0]  r_lfsr;
   logic [CNT_W-1:0]   r_cnt;
   logic [WC_W-1:0]    r_wcnt;
   logic [OUT_W-1:0]   r_acc;
   logic [OUT_W-1:0]   r_dout;
   logic               r_valid;

   logic               w_fb;
   logic               w_bit;
   logic [LFSR_W-1:0]  w_lfsr_nxt;
   logic [LFSR_W-1:0]  w_seed_eff;
   logic [OUT_W-1:0]   w_acc_nxt;
   logic               w_run;
   logic               w_warm_done;
   logic               w_xfer;
   logic               w_stall;

   assign w_fb       = ^(r_lfsr & TAPS);
   assign w_bit      = r_lfsr[LFSR_W-1];
   assign w_lfsr_nxt = {w_fb, r_lfsr[LFSR_W-1:1]};
   assign w_seed_eff = (i_seed_in == '0) ? SEED_SAFE : i_seed_in;

   // With no warm-up the very first enabled cycle already collects a bit.
   assign w_run       = (r_state == ST_RUN) || (WARMUP == 0);
   assign w_warm_done = (WARMUP == 0) || (r_wcnt == WC_LAST);

   assign w_xfer  = r_valid && o_stream.dout_ready;
   // Last bit of a word cannot be committed while the previous word is still held.
   assign w_stall = w_run && (r_cnt == CNT_LAST) && r_valid && !o_stream.dout_ready;

   // Accumulator with the current emitted bit merged in at the current position.
   always_comb begin
      w_acc_nxt        = r_acc;
      w_acc_nxt[r_cnt] = w_bit;
   end

   // Sequencer: reseed beats enable beats hold; handshake runs independently of enable.
   always_ff @(posedge i_clk or negedge i_res) begin
      if (!i_res) begin
         r_state <= ST_WARM;
         r_lfsr  <= SEED_SAFE;
         r_cnt   <= '0;
         r_wcnt  <= '0;
         r_acc   <= '0;
         r_dout  <= '0;
         r_valid <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_valid <= 1'b0;
         end

         if (i_seed_ld) begin
            r_state <= ST_WARM;
            r_lfsr  <= w_seed_eff;
            r_cnt   <= '0;
            r_wcnt  <= '0;
            r_acc   <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
         end else if (i_en) begin
            if (!w_run) begin
               r_lfsr <= w_lfsr_nxt;
               if (w_warm_done) begin
                  r_state <= ST_RUN;
                  r_wcnt  <= '0;
               end else begin
                  r_wcnt <= r_wcnt + 1'b1;
               end
            end else if (!w_stall) begin
               r_state <= ST_RUN;
               r_lfsr  <= w_lfsr_nxt;
               if (r_cnt == CNT_LAST) begin
                  // A completed word overrides a same-cycle transfer clear.
                  r_dout  <= w_acc_nxt;
                  r_valid <= 1'b1;
                  r_cnt   <= '0;
                  r_acc   <= '0;
               end else begin
                  r_acc <= w_acc_nxt;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end
      end
   end

   assign o_warm              = (r_state == ST_WARM);
   assign o_stream.dout       = r_dout;
   assign o_stream.dout_valid = r_valid;

endmodule

// File: tb/tb_lfsr_rng_stream.sv
// Randomised self-checking bench for lfsr_rng_stream against a bit-stream reference model.
module tb_lfsr_rng_stream;

   localparam logic [31:0] D_TAPS = 32'h8020_0003;
   localparam logic [31:0] D_SEED = 32'd3515;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        seed_ld;
   logic [31:0] seed_in;
   logic        warm;

   logic        en_s;
   logic        seed_ld_s;
   logic [3:0]  seed_in_s;
   logic        warm_s;

   int          n_chk;
   int          n_pass;

   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];

   lfsr_rng_stream_if #(.OUT_W(8)) u_bus ();
   lfsr_rng_stream_if #(.OUT_W(3)) u_bus_s ();

   lfsr_rng_stream u_dut (
      .i_clk     (clk),
      .i_res     (rst_n),
      .i_en      (en),
      .i_seed_ld (seed_ld),
      .i_seed_in (seed_in),
      .o_warm    (warm),
      .o_stream  (u_bus)
   );

   lfsr_rng_stream #(
      .LFSR_W (4),
      .TAPS   (4'b0011),
      .SEED   (4'h1),
      .OUT_W  (3),
      .WARMUP (0)
   ) u_small (
      .i_clk     (clk),
      .i_res     (rst_n),
      .i_en      (en_s),
      .i_seed_ld (seed_ld_s),
      .i_seed_in (seed_in_s),
      .o_warm    (warm_s),
      .o_stream  (u_bus_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: one Fibonacci shift of a w-bit register.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] taps, input int w);
      logic fb;
      fb = ^(s & taps);
      return (s >> 1) | ({31'b0, fb} << (w - 1));
   endfunction

   function automatic logic [31:0] lfsr_after(input logic [31:0] seed, input logic [31:0] taps,
                                               input int w, input int n);
      logic [31:0] s;
      s = seed;
      for (int i = 0; i < n; i++) s = lfsr_step(s, taps, w);
      return s;
   endfunction

   // Expected words: drop the warm-up bits, then pack emitted MSBs LSB-first.
   function automatic void build_exp(input logic [31:0] seed, input logic [31:0] taps, input int w,
                                     input int warmup, input int outw, input int n);
      logic [31:0] s;
      logic [31:0] word;
      exp_q.delete();
      s = seed;
      for (int i = 0; i < warmup; i++) s = lfsr_step(s, taps, w);
      for (int k = 0; k < n; k++) begin
         word = '0;
         for (int b = 0; b < outw; b++) begin
            word[b] = s[w-1];
            s = lfsr_step(s, taps, w);
         end
         exp_q.push_back(word);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      seed_ld = 1'b0;
      tick();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Drives random enable/ready and records every accepted word.
   task automatic collect(input int n, input int budget, input int en_pct, input int rdy_pct);
      got_q.delete();
      for (int c = 0; c < budget && got_q.size() < n; c++) begin
         en = ($urandom_range(99) < en_pct);
         u_bus.dout_ready = ($urandom_range(99) < rdy_pct);
         if (u_bus.dout_valid && u_bus.dout_ready) got_q.push_back(32'(u_bus.dout));
         tick();
      end
   endtask

   task automatic compare_stream(input string tag);
      int n;
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      chk_eq({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < n; i++) chk_eq($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
   endtask

   task automatic reseed(input logic [31:0] s, input string tag);
      seed_ld = 1'b1;
      seed_in = s;
      en      = 1'($urandom_range(1));
      u_bus.dout_ready = 1'b1;
      tick();
      seed_ld = 1'b0;
      en      = 1'b1;
      chk_eq({tag, "_valid_drop"}, 32'(u_bus.dout_valid), 0);
      chk_eq({tag, "_dout_clr"}, 32'(u_bus.dout), 0);
      chk_eq({tag, "_warm_set"}, 32'(warm), 1);
      for (int k = 1; k <= 33; k++) begin
         tick();
         if (k == 32) chk_eq({tag, "_warm_32"}, 32'(warm), 1);
         if (k == 33) chk_eq({tag, "_warm_33"}, 32'(warm), 0);
      end
   endtask

   initial begin
      int bad;
      n_chk     = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      en        = 1'b1;
      seed_ld   = 1'b0;
      seed_in   = '0;
      en_s      = 1'b0;
      seed_ld_s = 1'b0;
      seed_in_s = '0;
      u_bus.dout_ready   = 1'b1;
      u_bus_s.dout_ready = 1'b1;

      // Reset values and first-word latency.
      tick();
      chk_eq("rst_valid", 32'(u_bus.dout_valid), 0);
      chk_eq("rst_dout", 32'(u_bus.dout), 0);
      chk_eq("rst_warm", 32'(warm), 1);
      chk_eq("rst_lfsr", u_dut.r_lfsr, D_SEED);
      tick();
      tick();
      rst_n = 1'b1;
      build_exp(D_SEED, D_TAPS, 32, 33, 8, 1000);
      for (int k = 1; k <= 41; k++) begin
         tick();
         if (k == 32) chk_eq("lat_warm_32", 32'(warm), 1);
         if (k == 33) chk_eq("lat_warm_33", 32'(warm), 0);
         if (k == 40) chk_eq("lat_valid_40", 32'(u_bus.dout_valid), 0);
         if (k == 41) chk_eq("lat_valid_41", 32'(u_bus.dout_valid), 1);
      end
      collect(1000, 9000, 100, 100);
      compare_stream("cont");

      // Backpressure: word 0 held, lfsr frozen with 7 bits of word 1 collected.
      en = 1'b1;
      u_bus.dout_ready = 1'b0;
      do_reset();
      for (int c = 0; c < 200; c++) begin
         tick();
         if (u_bus.dout_valid) break;
      end
      chk_eq("bp_first_valid", 32'(u_bus.dout_valid), 1);
      build_exp(D_SEED, D_TAPS, 32, 33, 8, 40);
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (32'(u_bus.dout) != exp_q[0] || !u_bus.dout_valid) bad++;
      end
      chk_eq("bp_hold", 32'(bad), 0);
      chk_eq("bp_lfsr_frozen", u_dut.r_lfsr, lfsr_after(D_SEED, D_TAPS, 32, 48));
      collect(40, 600, 100, 100);
      compare_stream("bp");

      // Reseed mid-word: explicit seed, zero seed, random seed.
      do_reset();
      collect(5, 100, 100, 100);
      tick();
      tick();
      tick();
      reseed(32'h1234_5678, "rs1");
      build_exp(32'h1234_5678, D_TAPS, 32, 33, 8, 50);
      collect(50, 600, 100, 100);
      compare_stream("rs1");
      tick();
      tick();
      tick();
      reseed(32'h0, "rs0");
      build_exp(D_SEED, D_TAPS, 32, 33, 8, 50);
      collect(50, 600, 100, 100);
      compare_stream("rs0");
      seed_in = $urandom | 32'h1;
      tick();
      reseed(seed_in, "rsr");
      build_exp(seed_in, D_TAPS, 32, 33, 8, 50);
      collect(50, 1500, 60, 60);
      compare_stream("rsr");

      // Enable and ready both toggled randomly: same words, dilated timing.
      do_reset();
      build_exp(D_SEED, D_TAPS, 32, 33, 8, 200);
      collect(200, 6000, 50, 70);
      compare_stream("gate");

      // Asynchronous reset between edges during a stall.
      en = 1'b1;
      u_bus.dout_ready = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (u_bus.dout_valid) break;
         tick();
      end
      tick();
      tick();
      tick();
      #3;
      rst_n = 1'b0;
      #1;
      chk_eq("arst_valid", 32'(u_bus.dout_valid), 0);
      chk_eq("arst_dout", 32'(u_bus.dout), 0);
      chk_eq("arst_warm", 32'(warm), 1);
      chk_eq("arst_lfsr", u_dut.r_lfsr, D_SEED);
      tick();
      tick();
      rst_n = 1'b1;
      build_exp(D_SEED, D_TAPS, 32, 33, 8, 100);
      collect(100, 1200, 100, 100);
      compare_stream("post_rst");

      // Small maximal-length instance: period 15, never zero.
      en = 1'b0;
      do_reset();
      en_s = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         chk_eq($sformatf("per_lfsr[%0d]", k), 32'(u_small.r_lfsr), lfsr_after(32'h1, 32'h3, 4, k));
         chk_eq($sformatf("per_nonzero[%0d]", k), 32'(u_small.r_lfsr != 4'h0), 1);
      end
      chk_eq("per_return", 32'(u_small.r_lfsr), 32'h1);
      en_s = 1'b0;
      do_reset();
      en_s = 1'b1;
      u_bus_s.dout_ready = 1'b1;
      got_q.delete();
      for (int c = 0; c < 200 && got_q.size() < 30; c++) begin
         if (u_bus_s.dout_valid && u_bus_s.dout_ready) got_q.push_back(32'(u_bus_s.dout));
         tick();
      end
      build_exp(32'h1, 32'h3, 4, 0, 3, 30);
      compare_stream("small");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
